m_boot_ctrl: RTL and testbench

- Boot/run controller for the pipelined RV32I core.
- Replaces hard-coded preloading of instruction memory and fixed-time finish with a hardware sequence:
  - stream a program into instruction memory over a valid/ready port;
  - hold the core in reset while loading, then release it;
  - count run cycles and stop the core on a halt instruction, a cycle budget, or an abort.
- Sits between the bench/host loader and the core's imem write port, reset and run-enable inputs.

---
 rtl/m_boot_ctrl_pkg.sv | 19 +
 rtl/m_sat_counter.sv | 21 ++
 rtl/m_boot_ctrl.sv | 136 +++++++++++++
 tb/tb_m_boot_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/m_boot_ctrl_pkg.sv
// Shared encodings for the boot/run controller: FSM states, stop-cause codes
// and the default halt instruction (ebreak).
package m_boot_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_HALT  = 2'd1;
  localparam logic [1:0] CAUSE_LIMIT = 2'd2;
  localparam logic [1:0] CAUSE_ABORT = 2'd3;

  localparam logic [31:0] HALT_INSN_DEFAULT = 32'h0010_0073;

endpackage

// File: rtl/m_sat_counter.sv
// Saturating up-counter with synchronous clear; one-cycle update latency,
// no flow control (holds at all-ones instead of wrapping).
module m_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/m_boot_ctrl.sv
// Boot/run controller: streams a program into imem (write path same-cycle, ready
// decoded from state so never depends on valid), then runs the core until halt/limit/abort.
module m_boot_ctrl
  import m_boot_ctrl_pkg::*;
#(
  parameter int                ADDR_W    = 10,
  parameter int                DATA_W    = 32,
  parameter int                CNT_W     = 32,
  parameter logic [DATA_W-1:0] HALT_INSN = DATA_W'(HALT_INSN_DEFAULT)
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_start,
  input  logic              w_abort,
  input  logic [CNT_W-1:0]  w_cycle_limit,
  input  logic              w_ld_valid,
  input  logic [DATA_W-1:0] w_ld_data,
  input  logic              w_ld_last,
  output logic              w_ld_ready,
  output logic              w_im_we,
  output logic [ADDR_W-1:0] w_im_addr,
  output logic [DATA_W-1:0] w_im_wdata,
  output logic              w_core_rst,
  output logic              w_run,
  input  logic [DATA_W-1:0] w_ir,
  input  logic              w_ir_valid,
  output logic              w_done,
  output logic [1:0]        w_cause,
  output logic              w_trunc,
  output logic [ADDR_W:0]   w_nwords,
  output logic [CNT_W-1:0]  w_cycles
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        cause_nxt;
  logic              start_acc;
  logic              set_trunc;
  logic              ld_hs;
  logic              halt_hit;
  logic              limit_hit;

  assign ld_hs     = (state == S_LOAD) && w_ld_valid;
  assign halt_hit  = w_ir_valid && (w_ir == HALT_INSN);
  // Compare one bit wider so a saturated counter cannot alias to limit 0.
  assign limit_hit = (w_cycle_limit != '0) &&
                     (({1'b0, w_cycles} + (CNT_W+1)'(1)) == {1'b0, w_cycle_limit});

  always_comb begin
    state_nxt = state;
    cause_nxt = CAUSE_NONE;
    start_acc = 1'b0;
    set_trunc = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (w_start) begin
          state_nxt = S_LOAD;
          start_acc = 1'b1;
        end
      end
      S_LOAD: begin
        if (ld_hs) begin
          if (w_ld_last) begin
            state_nxt = S_RUN;
          end else if (addr == '1) begin
            state_nxt = S_RUN;
            set_trunc = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (halt_hit) begin
          state_nxt = S_DONE;
          cause_nxt = CAUSE_HALT;
        end else if (limit_hit) begin
          state_nxt = S_DONE;
          cause_nxt = CAUSE_LIMIT;
        end else if (w_abort) begin
          state_nxt = S_DONE;
          cause_nxt = CAUSE_ABORT;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign w_ld_ready = (state == S_LOAD);
  assign w_im_we    = ld_hs;
  assign w_im_addr  = addr;
  assign w_im_wdata = w_ld_data;

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state      <= S_IDLE;
      addr       <= '0;
      w_nwords   <= '0;
      w_cause    <= CAUSE_NONE;
      w_trunc    <= 1'b0;
      w_core_rst <= 1'b1;
      w_run      <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      state      <= state_nxt;
      // Control outputs follow the next state so they line up with it exactly.
      w_core_rst <= (state_nxt == S_IDLE) || (state_nxt == S_LOAD);
      w_run      <= (state_nxt == S_RUN);
      w_done     <= (state_nxt == S_DONE);
      if (start_acc) begin
        addr     <= '0;
        w_nwords <= '0;
        w_cause  <= CAUSE_NONE;
        w_trunc  <= 1'b0;
      end else begin
        if (ld_hs) begin
          addr     <= addr + ADDR_W'(1);
          w_nwords <= w_nwords + (ADDR_W+1)'(1);
        end
        if (set_trunc) begin
          w_trunc <= 1'b1;
        end
        if ((state == S_RUN) && (state_nxt == S_DONE)) begin
          w_cause <= cause_nxt;
        end
      end
    end
  end

  m_sat_counter #(.W(CNT_W)) u_cycles (
    .clk (w_clk),
    .rst (w_rst),
    .clr (start_acc),
    .en  (state == S_RUN),
    .q   (w_cycles)
  );

endmodule

// File: tb/tb_m_boot_ctrl.sv
// Directed self-checking bench for m_boot_ctrl, built with a 4-word imem so
// the truncation boundary is reachable.
module tb_m_boot_ctrl;

  localparam int AW = 2;
  localparam int DW = 32;
  localparam int CW = 32;
  localparam logic [31:0] HALT = 32'h0010_0073;

  logic          clk = 1'b0;
  logic          rst, start, abort_i, ld_valid, ld_last, ld_ready;
  logic [CW-1:0] cycle_limit;
  logic [DW-1:0] ld_data, ir, im_wdata;
  logic          ir_valid, im_we, core_rst, run, done, trunc;
  logic [AW-1:0] im_addr;
  logic [1:0]    cause;
  logic [AW:0]   nwords;
  logic [CW-1:0] cycles;

  int n_cmp  = 0;
  int n_fail = 0;

  int          log_addr[$];
  logic [31:0] log_data[$];
  logic [31:0] prog [0:2];

  always #5 clk = ~clk;

  m_boot_ctrl #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .HALT_INSN(HALT)) dut (
    .w_clk(clk), .w_rst(rst), .w_start(start), .w_abort(abort_i),
    .w_cycle_limit(cycle_limit), .w_ld_valid(ld_valid), .w_ld_data(ld_data),
    .w_ld_last(ld_last), .w_ld_ready(ld_ready), .w_im_we(im_we),
    .w_im_addr(im_addr), .w_im_wdata(im_wdata), .w_core_rst(core_rst),
    .w_run(run), .w_ir(ir), .w_ir_valid(ir_valid), .w_done(done),
    .w_cause(cause), .w_trunc(trunc), .w_nwords(nwords), .w_cycles(cycles)
  );

  // imem write log, sampled mid-cycle when inputs are stable
  always @(negedge clk) begin
    if (im_we) begin
      log_addr.push_back(int'(im_addr));
      log_data.push_back(im_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_one(input logic [31:0] d);
    ld_valid = 1'b1; ld_data = d; ld_last = 1'b1;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_cmp++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL reset_core_rst: got %b want 1", core_rst); end
    n_cmp++; if ({run, done, trunc, ld_ready, im_we} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", {run, done, trunc, ld_ready, im_we}); end
    n_cmp++; if (cycles !== 0 || nwords !== 0 || cause !== 0) begin n_fail++; $display("FAIL reset_counts: got cyc=%0d nw=%0d cause=%0d want 0 0 0", cycles, nwords, cause); end
    rst = 1'b0;
    tick();
    n_cmp++; if (core_rst !== 1'b1 || ld_ready !== 1'b0 || run !== 1'b0) begin n_fail++; $display("FAIL idle_outputs: got crst=%b rdy=%b run=%b want 1 0 0", core_rst, ld_ready, run); end
  endtask

  task automatic test_load_halt();
    log_addr.delete(); log_data.delete();
    do_start();
    n_cmp++; if (ld_ready !== 1'b1 || core_rst !== 1'b1 || run !== 1'b0) begin n_fail++; $display("FAIL load_outputs: got rdy=%b crst=%b run=%b want 1 1 0", ld_ready, core_rst, run); end
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_data = prog[i]; ld_last = (i == 2);
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    n_cmp++; if (run !== 1'b1 || core_rst !== 1'b0 || ld_ready !== 1'b0) begin n_fail++; $display("FAIL run_entry: got run=%b crst=%b rdy=%b want 1 0 0", run, core_rst, ld_ready); end
    n_cmp++; if (nwords !== 3 || log_addr.size() != 3) begin n_fail++; $display("FAIL load_count: got nwords=%0d writes=%0d want 3 3", nwords, log_addr.size()); end
    for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
      n_cmp++; if (log_addr[i] != i || log_data[i] !== prog[i]) begin n_fail++; $display("FAIL load_write%0d: got addr=%0d data=%h want %0d %h", i, log_addr[i], log_data[i], i, prog[i]); end
    end
    // halt retires on RUN cycle 5; cycle 3 carries the encoding as a bubble
    for (int c = 1; c <= 5; c++) begin
      ir_valid = (c != 3);
      ir = (c == 5 || c == 3) ? HALT : prog[0];
      tick();
    end
    ir_valid = 1'b0; ir = '0;
    n_cmp++; if (done !== 1'b1 || cause !== 2'd1 || cycles !== 5) begin n_fail++; $display("FAIL halt: got done=%b cause=%0d cyc=%0d want 1 1 5", done, cause, cycles); end
    n_cmp++; if (run !== 1'b0 || core_rst !== 1'b0) begin n_fail++; $display("FAIL done_outputs: got run=%b crst=%b want 0 0", run, core_rst); end
    tick(); tick();
    n_cmp++; if (cycles !== 5 || cause !== 2'd1 || done !== 1'b1) begin n_fail++; $display("FAIL done_frozen: got cyc=%0d cause=%0d done=%b want 5 1 1", cycles, cause, done); end
  endtask

  task automatic test_cycle_limit();
    int n;
    cycle_limit = 10;
    do_start();
    n_cmp++; if (core_rst !== 1'b1 || done !== 1'b0 || cycles !== 0 || cause !== 0) begin n_fail++; $display("FAIL restart_clears: got crst=%b done=%b cyc=%0d cause=%0d want 1 0 0 0", core_rst, done, cycles, cause); end
    load_one(32'h0000_0013);
    n = 0;
    for (int k = 0; k < 50 && done !== 1'b1; k++) begin
      if (run === 1'b1) n++;
      tick();
    end
    n_cmp++; if (n != 10) begin n_fail++; $display("FAIL limit_run_len: got %0d want 10", n); end
    n_cmp++; if (done !== 1'b1 || cause !== 2'd2 || cycles !== 10) begin n_fail++; $display("FAIL limit_stop: got done=%b cause=%0d cyc=%0d want 1 2 10", done, cause, cycles); end
    // unlimited budget; start mid-run must be ignored
    cycle_limit = 0;
    do_start();
    load_one(32'h0000_0013);
    for (int k = 0; k < 300; k++) begin
      start = (k == 100);
      tick();
    end
    start = 1'b0;
    n_cmp++; if (run !== 1'b1 || done !== 1'b0 || cycles !== 300) begin n_fail++; $display("FAIL unlimited: got run=%b done=%b cyc=%0d want 1 0 300", run, done, cycles); end
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    n_cmp++; if (done !== 1'b1 || cause !== 2'd3 || cycles !== 301) begin n_fail++; $display("FAIL abort: got done=%b cause=%0d cyc=%0d want 1 3 301", done, cause, cycles); end
  endtask

  task automatic test_backpressure();
    logic [5:0] pat;
    int w;
    pat = 6'b101101;  // slot 0 first: 1,0,1,1,0,1
    log_addr.delete(); log_data.delete();
    do_start();
    w = 0;
    for (int s = 0; s < 6; s++) begin
      ld_valid = pat[5-s];
      ld_data  = 32'hA000_0000 + 32'(w);
      ld_last  = pat[5-s] && (w == 3);
      abort_i  = !pat[5-s];
      start    = !pat[5-s];
      tick();
      if (pat[5-s]) w++;
    end
    ld_valid = 1'b0; ld_last = 1'b0; abort_i = 1'b0; start = 1'b0;
    n_cmp++; if (log_addr.size() != 4 || nwords !== 4) begin n_fail++; $display("FAIL bp_count: got writes=%0d nwords=%0d want 4 4", log_addr.size(), nwords); end
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      n_cmp++; if (log_addr[i] != i || log_data[i] !== 32'hA000_0000 + 32'(i)) begin n_fail++; $display("FAIL bp_write%0d: got addr=%0d data=%h want %0d %h", i, log_addr[i], log_data[i], i, 32'hA000_0000 + 32'(i)); end
    end
    n_cmp++; if (ld_ready !== 1'b0 || run !== 1'b1 || trunc !== 1'b0) begin n_fail++; $display("FAIL bp_after_last: got rdy=%b run=%b trunc=%b want 0 1 0", ld_ready, run, trunc); end
    abort_i = 1'b1; tick(); abort_i = 1'b0;
  endtask

  task automatic test_truncation();
    log_addr.delete(); log_data.delete();
    do_start();
    for (int i = 0; i < 6; i++) begin
      ld_valid = 1'b1; ld_data = 32'hB000_0000 + 32'(i); ld_last = 1'b0;
      tick();
    end
    ld_valid = 1'b0;
    n_cmp++; if (log_addr.size() != 4 || nwords !== 4) begin n_fail++; $display("FAIL trunc_count: got writes=%0d nwords=%0d want 4 4", log_addr.size(), nwords); end
    n_cmp++; if (log_addr.size() == 4 && log_addr[3] != 3) begin n_fail++; $display("FAIL trunc_last_addr: got %0d want 3", log_addr[3]); end
    n_cmp++; if (trunc !== 1'b1 || run !== 1'b1 || ld_ready !== 1'b0) begin n_fail++; $display("FAIL trunc_state: got trunc=%b run=%b rdy=%b want 1 1 0", trunc, run, ld_ready); end
    n_cmp++; if (cycles !== 2) begin n_fail++; $display("FAIL trunc_cycles: got %0d want 2", cycles); end
    abort_i = 1'b1; tick(); abort_i = 1'b0;
    n_cmp++; if (trunc !== 1'b1 || cause !== 2'd3) begin n_fail++; $display("FAIL trunc_frozen: got trunc=%b cause=%0d want 1 3", trunc, cause); end
  endtask

  task automatic test_simultaneous();
    cycle_limit = 3;
    do_start();
    n_cmp++; if (trunc !== 1'b0) begin n_fail++; $display("FAIL trunc_cleared: got %b want 0", trunc); end
    load_one(32'h0000_0013);
    tick(); tick();
    ir = HALT; ir_valid = 1'b1; abort_i = 1'b1;
    tick();
    ir_valid = 1'b0; abort_i = 1'b0;
    n_cmp++; if (cause !== 2'd1 || cycles !== 3 || done !== 1'b1) begin n_fail++; $display("FAIL prio_halt: got cause=%0d cyc=%0d done=%b want 1 3 1", cause, cycles, done); end
    do_start();
    load_one(32'h0000_0013);
    tick(); tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    n_cmp++; if (cause !== 2'd2 || cycles !== 3) begin n_fail++; $display("FAIL prio_limit: got cause=%0d cyc=%0d want 2 3", cause, cycles); end
    cycle_limit = 1;
    do_start();
    load_one(32'h0000_0013);
    tick();
    n_cmp++; if (cause !== 2'd2 || cycles !== 1 || done !== 1'b1) begin n_fail++; $display("FAIL limit_one: got cause=%0d cyc=%0d done=%b want 2 1 1", cause, cycles, done); end
  endtask

  task automatic test_reset_restart();
    cycle_limit = 0;
    do_start();
    load_one(32'h0000_0013);
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (core_rst !== 1'b1 || run !== 1'b0 || ld_ready !== 1'b0) begin n_fail++; $display("FAIL midrun_reset: got crst=%b run=%b rdy=%b want 1 0 0", core_rst, run, ld_ready); end
    n_cmp++; if (cycles !== 0 || nwords !== 0 || done !== 1'b0) begin n_fail++; $display("FAIL midrun_counts: got cyc=%0d nw=%0d done=%b want 0 0 0", cycles, nwords, done); end
    do_start();
    load_one(32'h0000_0013);
    tick(); tick();
    abort_i = 1'b1; tick(); abort_i = 1'b0;
    n_cmp++; if (done !== 1'b1 || cycles !== 3) begin n_fail++; $display("FAIL pre_restart: got done=%b cyc=%0d want 1 3", done, cycles); end
    do_start();
    load_one(32'h0000_0013);
    tick();
    n_cmp++; if (cycles !== 1 || run !== 1'b1 || nwords !== 1) begin n_fail++; $display("FAIL restart_count: got cyc=%0d run=%b nw=%0d want 1 1 1", cycles, run, nwords); end
  endtask

  initial begin
    prog[0] = 32'h0070_0093;  // addi x1,x0,7
    prog[1] = 32'h0010_2423;  // sw x1,8(x0)
    prog[2] = 32'h0010_0073;  // ebreak
    rst = 1'b1; start = 1'b0; abort_i = 1'b0; cycle_limit = '0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0; ir = '0; ir_valid = 1'b0;
    test_reset();
    test_load_halt();
    test_cycle_limit();
    test_backpressure();
    test_truncation();
    test_simultaneous();
    test_reset_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
